sdm_modulator: RTL and testbench
================================

# sdm_modulator

Second-order 1-bit sigma-delta modulator: converts a stream of signed PCM samples into a 1-bit oversampled bitstream, one bit per clock. It is the transmit counterpart of sdm_demodulator and drives its valid_in/din pair directly, enabling loopback of the DSD-rate (2.8224 MHz) path. Each accepted sample is held for OSR clocks, through a one-entry skid buffer with a valid/ready handshake.

## Interface
- DATA_W, 16: input sample width, signed two's complement.
- OSR, 64: output bits per input sample (oversampling ratio), ≥ 2.
- ACC_W, DATA_W+4: integrator width, signed.

- clk  in  1  bit clock; one output bit per rising edge while running.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear back to IDLE.
- valid_in  in  1  din is a valid sample.
- din  in  DATA_W  signed PCM sample.
- ready_in  out  1  block can accept a sample this cycle.
- valid_out  out  1  dout carries a modulator bit.
- dout  out  1  bitstream; 1 = +FS, 0 = −FS.
- underrun  out  1  one-cycle pulse: sample boundary reached with no pending sample.

## Operation
- FS = 2^(DATA_W−1). fb = dout ? +FS : −FS, using the registered dout.
- States: IDLE, RUN.
- IDLE:
  - ready_in=1, valid_out=0, dout=0, underrun=0.
  - i1=i2=0, phase=0, pending empty.
  - On valid_in: active ← din and state → RUN.
- RUN, every cycle:
  - i1' = sat(i1 + sx(active) − fb).
  - i2' = sat(i2 + i1' − fb).
  - dout ← (i2' ≥ 0); valid_out ← 1.
  - sat clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - All sums are formed at ACC_W+2 bits before clamping; sx() sign-extends.
- Skid buffer:
  - ready_in = !pending_full in RUN.
  - valid_in && ready_in loads pending and sets pending_full.
- Phase counter:
  - Counts 0..OSR−1 in RUN.
  - On the edge where phase = OSR−1: phase ← 0. If pending_full, active ← pending and pending_full ← 0; otherwise active is kept and underrun pulses for one cycle.
  - The integrator update on that edge uses the old active value.
- Simultaneous accept and boundary (pending was empty): the new sample goes to pending, not active, and underrun still pulses.
- clear, or rst_n low, in any state: everything returns to IDLE values. clear has priority over valid_in. A pending sample is discarded.

## Timing
- Reset values: ready_in=1, valid_out=0, dout=0, underrun=0. The rst_n assertion takes effect immediately (asynchronous).
- Start-up sequence after a sample is accepted in IDLE at edge E0:
  - E0: state → RUN.
  - E1: first integrator update; valid_out=1 and the first dout are visible after E1.
  - In-to-out latency is 2 cycles from valid_in.
- After start-up, valid_out stays 1 every cycle until clear or reset, including during underrun (the last sample repeats).
- Sample cadence:
  - Each active value drives exactly OSR consecutive updates.
  - Samples transfer every OSR cycles; underrun cycles are spaced by multiples of OSR.
- Throughput: 1 sample per OSR clocks. With pending full, ready_in stays 0 until the cycle after the next boundary.
- dout has no combinational path from din.

## Test plan
- Reset: hold rst_n=0, toggle din/valid_in -> ready_in=1, valid_out=0, dout=0. Assert rst_n mid-RUN -> outputs return to reset values immediately, asynchronously.
- DC response: continuous 0x0000 for 4096 bits -> ones count 2048±8. +16384 -> ones density 75%±1%. −16384 -> 25%±1%.
- Latency/cadence: OSR=8, single accept at cycle 10 -> valid_out first high at cycle 12. With no further samples, underrun pulses at cycles 19, 27, 35.
- Backpressure: valid_in held high with a ramp -> each sample accepted exactly once, with no loss or duplication. ready_in low from the cycle after each accept until the following boundary. No underrun pulses.
- Saturation: −32768 held for 512 bits -> i1/i2 clamp with no wraparound. Then 0 -> ones density returns to 50%±2% within 256 bits.
- clear mid-RUN with a pending sample -> next cycle is IDLE, valid_out=0. The next accepted sample restarts with zeroed integrators and the discarded sample is never used. A bitstream matching the reference model is checked bit-exact.

Source files
------------

// File: rtl/sdm_modulator.sv
// rtl/sdm_modulator.sv - second-order 1-bit sigma-delta modulator
// Each accepted PCM sample drives OSR integrator updates; a one-entry skid buffer stages the next sample.
module sdm_modulator #(
  parameter int DATA_W = 16,
  parameter int OSR    = 64,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] din,
  output logic                     ready_in,
  output logic                     valid_out,
  output logic                     dout,
  output logic                     underrun
);

  localparam int SUM_W = ACC_W + 2;
  localparam int PH_W  = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

  localparam logic signed [SUM_W-1:0] FS_POS =
    {{(SUM_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FS_NEG = -FS_POS;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state;
  logic signed [ACC_W-1:0]    i1, i2;
  logic signed [ACC_W-1:0]    i1_next, i2_next;
  logic signed [DATA_W-1:0]   active, pending;
  logic                       pending_full;
  logic [PH_W-1:0]            phase;
  logic signed [SUM_W-1:0]    fb, sum1, sum2;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[ACC_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[ACC_W-1:0];
    else
      return v[ACC_W-1:0];
  endfunction

  // Feedback uses the registered bit, so dout never depends combinationally on din.
  always_comb begin
    fb      = dout ? FS_POS : FS_NEG;
    sum1    = {{2{i1[ACC_W-1]}}, i1}
            + {{(SUM_W-DATA_W){active[DATA_W-1]}}, active} - fb;
    i1_next = sat(sum1);
    sum2    = {{2{i2[ACC_W-1]}}, i2} + {{2{i1_next[ACC_W-1]}}, i1_next} - fb;
    i2_next = sat(sum2);
  end

  assign ready_in = (state == IDLE) || !pending_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      i1           <= '0;
      i2           <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      phase        <= '0;
      valid_out    <= 1'b0;
      dout         <= 1'b0;
      underrun     <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      i1           <= '0;
      i2           <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      phase        <= '0;
      valid_out    <= 1'b0;
      dout         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            active <= din;
            phase  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          i1        <= i1_next;
          i2        <= i2_next;
          dout      <= ~i2_next[ACC_W-1];
          valid_out <= 1'b1;
          // The update above still uses the old active value on a boundary edge.
          if (phase == PH_LAST) begin
            phase <= '0;
            if (pending_full) begin
              active       <= pending;
              pending_full <= 1'b0;
              underrun     <= 1'b0;
            end else begin
              underrun <= 1'b1;
            end
          end else begin
            phase    <= phase + 1'b1;
            underrun <= 1'b0;
          end
          if (valid_in && !pending_full) begin
            pending      <= din;
            pending_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdm_modulator.sv
// tb/tb_sdm_modulator.sv - scoreboard bench for sdm_modulator against a cycle model
module tb_sdm_modulator;

  localparam int OSR = 8;
  localparam int FS  = 32768;
  localparam int LO  = -524288;
  localparam int HI  = 524287;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               valid_in = 1'b0;
  logic signed [15:0] din = '0;
  logic               ready_in, valid_out, dout, underrun;

  sdm_modulator #(.DATA_W(16), .OSR(OSR), .ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .din(din),
    .ready_in(ready_in), .valid_out(valid_out), .dout(dout), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit m_run, m_pfull, m_dout, m_vout, m_urun;
  int m_i1, m_i2, m_active, m_pend, m_phase;

  function automatic int clamp(input int v);
    if (v > HI) return HI;
    if (v < LO) return LO;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pfull = 0; m_dout = 0; m_vout = 0; m_urun = 0;
    m_i1 = 0; m_i2 = 0; m_active = 0; m_pend = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input int d);
    bit rdy;
    int fbv;
    rdy = !m_run || !m_pfull;
    if (c) begin
      model_reset();
    end else if (!m_run) begin
      if (v) begin
        m_active = d;
        m_run    = 1;
        m_phase  = 0;
      end
    end else begin
      fbv    = m_dout ? FS : -FS;
      m_i1   = clamp(m_i1 + m_active - fbv);
      m_i2   = clamp(m_i2 + m_i1 - fbv);
      m_dout = (m_i2 >= 0);
      m_vout = 1;
      if (m_phase == OSR - 1) begin
        m_phase = 0;
        if (m_pfull) begin
          m_active = m_pend;
          m_pfull  = 0;
          m_urun   = 0;
        end else begin
          m_urun = 1;
        end
      end else begin
        m_phase++;
        m_urun = 0;
      end
      if (v && rdy) begin
        m_pend  = d;
        m_pfull = 1;
      end
    end
  endtask

  logic [2:0] exp_q[$];
  int         urun_q[$];
  int         ones, bits, acc_cnt, urun_cnt, first_vout;

  task automatic step(input logic v, input logic signed [15:0] d, input logic c);
    logic [2:0] got;
    logic [2:0] expv;
    bit         m_ready;
    valid_in = v;
    din      = d;
    clear    = c;
    #1;
    m_ready = !m_run || !m_pfull;
    check("ready_in", 32'(ready_in), 32'(m_ready));
    if (v && ready_in && !c) acc_cnt++;
    model_step(c, v, int'(d));
    exp_q.push_back({m_vout, m_dout, m_urun});
    @(posedge clk);
    #1;
    got  = {valid_out, dout, underrun};
    expv = exp_q.pop_front();
    check("vout_dout_urun", 32'(got), 32'(expv));
    if (valid_out) begin
      bits++;
      if (dout) ones++;
      if (first_vout < 0) first_vout = cyc;
    end
    if (underrun) begin
      urun_cnt++;
      urun_q.push_back(cyc);
    end
  endtask

  task automatic run_dc(input logic signed [15:0] val, input int skip, input int n,
                        input int target, input int tol, input string tag);
    int dev;
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < skip; i++) step(1'b1, val, 1'b0);
    ones = 0;
    bits = 0;
    for (int i = 0; i < n; i++) step(1'b1, val, 1'b0);
    dev = ones - target;
    check(tag, (dev > tol || dev < -tol) ? dev : 0, 0);
    check({tag, "_bits"}, bits, n);
  endtask

  initial begin
    int c0;
    int guard;
    model_reset();

    // Reset held: outputs idle regardless of inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      valid_in = 1'($urandom);
      din      = 16'($urandom);
      #1;
      check("rst_ready", 32'(ready_in), 1);
      check("rst_vout", 32'(valid_out), 0);
      check("rst_dout", 32'(dout), 0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Latency and underrun cadence
    urun_q.delete();
    first_vout = -1;
    c0 = cyc;
    step(1'b1, 16'sd1000, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0);
    check("latency", first_vout - c0, 2);
    for (int k = 0; k < 3; k++)
      check("urun_cycle", (k < urun_q.size()) ? urun_q[k] - c0 : -1, 9 + 8 * k);

    // Accept exactly on a boundary with pending empty
    guard = 0;
    while (m_phase != OSR - 1 && guard < 2 * OSR) begin
      step(1'b0, '0, 1'b0);
      guard++;
    end
    check("bnd_reached", m_phase, OSR - 1);
    urun_cnt = 0;
    step(1'b1, -16'sd2000, 1'b0);
    check("bnd_urun", urun_cnt, 1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);

    // DC response
    run_dc(16'sd0, 64, 4096, 2048, 8, "dc_zero");
    run_dc(16'sd16384, 64, 4096, 3072, 41, "dc_pos");
    run_dc(-16'sd16384, 64, 4096, 1024, 41, "dc_neg");

    // Backpressure with a ramp: one accept per OSR, no underrun
    step(1'b0, '0, 1'b1);
    acc_cnt  = 0;
    urun_cnt = 0;
    begin
      logic signed [15:0] ramp;
      ramp = -16'sd12000;
      for (int i = 0; i < 160; i++) begin
        int prev;
        prev = acc_cnt;
        step(1'b1, ramp, 1'b0);
        if (acc_cnt != prev) ramp = ramp + 16'sd1500;
      end
    end
    check("bp_accepts", acc_cnt, 21);
    check("bp_underruns", urun_cnt, 0);

    // Saturation then recovery
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 512; i++) step(1'b1, -16'sd32768, 1'b0);
    check("sat_clamped", m_i2, LO);
    for (int i = 0; i < 256; i++) step(1'b1, 16'sd0, 1'b0);
    ones = 0;
    bits = 0;
    for (int i = 0; i < 512; i++) step(1'b1, 16'sd0, 1'b0);
    check("sat_recover", (ones - 256 > 10 || ones - 256 < -10) ? ones - 256 : 0, 0);

    // clear with a pending sample, then restart
    step(1'b0, '0, 1'b1);
    step(1'b1, 16'sd5000, 1'b0);
    step(1'b1, -16'sd7000, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 16'sd12345, 1'b1);
    check("clr_vout", 32'(valid_out), 0);
    step(1'b1, -16'sd3000, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 20; i++) step(1'b1, 16'sd9000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready_in), 1);
    check("arst_vout", 32'(valid_out), 0);
    check("arst_dout", 32'(dout), 0);
    check("arst_urun", 32'(underrun), 0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 16'sd777, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
